// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO-side types: reader state encoding and default word width
package fifo_pkg;

    localparam int DEFAULT_BITNUMBER = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

endpackage

// File: rtl/skid_buffer.sv
// rtl/skid_buffer.sv - circular skid buffer with push, pop, occupancy count and head data
module skid_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - drains a fixed-latency FIFO into a valid/ready sink through a skid buffer
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int BITNUMBER = DEFAULT_BITNUMBER,
    parameter int READ_LAT  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic                 fifo_almost_empty,
    input  logic                 fifo_rd_error,
    input  logic [BITNUMBER-1:0] fifo_data,
    output logic                 fifo_rd,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [BITNUMBER-1:0] out_data,
    output logic                 busy,
    output logic [15:0]          words_read,
    output logic [7:0]           rd_err_count
);

    localparam int SKID_DEPTH = READ_LAT + 2;
    localparam int CNT_W      = $clog2(SKID_DEPTH + 1);

    state_t              state;
    state_t              state_next;
    logic [READ_LAT-1:0] rd_pipe;
    logic [READ_LAT-1:0] rd_pipe_next;
    logic [CNT_W-1:0]    inflight;
    logic [CNT_W-1:0]    skid_count;
    logic                rd_next;
    logic                push;
    logic                pop;

    // rd_pipe[0] is the read registered this cycle; the tail bit tags the word on fifo_data.
    assign fifo_rd   = rd_pipe[0];
    assign push      = rd_pipe[READ_LAT-1];
    assign out_valid = (skid_count != '0);
    assign pop       = out_valid && out_ready;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LAT; i++) begin
            inflight = inflight + CNT_W'(rd_pipe[i]);
        end
    end

    // Each in-flight read holds a reserved skid slot, so a stalled sink can never overflow it.
    assign rd_next = (state == ST_STREAM) && enable && !fifo_empty
                     && !(fifo_almost_empty && fifo_rd)
                     && (({1'b0, skid_count} + {1'b0, inflight}) < (CNT_W+1)'(SKID_DEPTH));

    always_comb begin
        rd_pipe_next    = '0;
        rd_pipe_next[0] = rd_next;
        for (int i = 1; i < READ_LAT; i++) begin
            rd_pipe_next[i] = rd_pipe[i-1];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (enable) state_next = ST_STREAM;
            ST_STREAM: if (!enable) state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (enable) begin
                    state_next = ST_STREAM;
                end else if (inflight == '0 && skid_count == '0) begin
                    state_next = ST_IDLE;
                end
            end
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            rd_pipe      <= '0;
            busy         <= 1'b0;
            words_read   <= '0;
            rd_err_count <= '0;
        end else begin
            state   <= state_next;
            rd_pipe <= rd_pipe_next;
            busy    <= (state_next != ST_IDLE) || (rd_pipe_next != '0);
            if (pop) begin
                words_read <= words_read + 16'd1;
            end
            if (fifo_rd_error && rd_err_count != 8'hFF) begin
                rd_err_count <= rd_err_count + 8'd1;
            end
        end
    end

    skid_buffer #(
        .WIDTH (BITNUMBER),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (fifo_data),
        .pop       (pop),
        .count     (skid_count),
        .head_data (out_data)
    );

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - directed vector bench for fifo_reader against a READ_LAT=2 FIFO model
module tb_fifo_reader;
    import fifo_pkg::*;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        reset, enable, out_ready, ext_err;
    logic        fifo_empty, fifo_almost_empty, fifo_rd_error, fifo_rd;
    logic        out_valid, busy, model_err;
    logic [7:0]  fifo_data, out_data, rd_err_count;
    logic [15:0] words_read;

    logic [7:0]  fmem [64];
    logic [7:0]  acc_q [$];
    int wr_ptr    = 0;
    int rd_ptr    = 0;
    int rd_pulses = 0;
    int max_skid  = 0;
    int n_vec     = 0;
    int n_miss    = 0;
    int base, p0;

    typedef struct {
        logic        en;
        logic        rdy;
        logic        exp_rd;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic        exp_busy;
        logic [15:0] exp_words;
    } vec_t;
    vec_t vecs [14];

    fifo_reader dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .fifo_empty        (fifo_empty),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_rd_error     (fifo_rd_error),
        .fifo_data         (fifo_data),
        .fifo_rd           (fifo_rd),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .busy              (busy),
        .words_read        (words_read),
        .rd_err_count      (rd_err_count)
    );

    always #5 clk = ~clk;

    // FIFO whose flags reflect the count before the read registered at this edge.
    assign fifo_empty        = (wr_ptr == rd_ptr);
    assign fifo_almost_empty = ((wr_ptr - rd_ptr) == 1);
    assign fifo_rd_error     = model_err | ext_err;

    always @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= wr_ptr;
            model_err <= 1'b0;
            fifo_data <= 8'h00;
        end else begin
            model_err <= 1'b0;
            if (fifo_rd) begin
                rd_pulses <= rd_pulses + 1;
                if (wr_ptr == rd_ptr) begin
                    model_err <= 1'b1;
                end else begin
                    fifo_data <= fmem[rd_ptr[5:0]];
                    rd_ptr    <= rd_ptr + 1;
                end
            end
            if (out_valid && out_ready) acc_q.push_back(out_data);
            if (int'(dut.skid_count) > max_skid) max_skid <= int'(dut.skid_count);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] v);
        fmem[wr_ptr[5:0]] = v;
        wr_ptr++;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 30 && busy; i++) @(negedge clk);
        check(name, int'(busy), 0);
    endtask

    function automatic int acc_at(input int idx);
        return (acc_q.size() > idx) ? int'(acc_q[idx]) : -1;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Eight words 0x11..0x18 streamed with the sink always ready.
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'd0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 16'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 16'd0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 16'd0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 1'b1, 16'd1};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h13, 1'b1, 16'd2};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h14, 1'b1, 16'd3};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h15, 1'b1, 16'd4};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h16, 1'b1, 16'd5};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h17, 1'b1, 16'd6};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h18, 1'b1, 16'd7};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'd8};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'd8};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd8};

        reset = 1'b1; enable = 1'b0; out_ready = 1'b1; ext_err = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_fifo_rd", int'(fifo_rd), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_words_read", int'(words_read), 0);
        check("rst_err_count", int'(rd_err_count), 0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) load(8'h11 + 8'(i));

        for (int i = 0; i < 14; i++) begin
            enable = vecs[i].en;
            out_ready = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("v%0d_fifo_rd", i), int'(fifo_rd), int'(vecs[i].exp_rd));
            check($sformatf("v%0d_out_valid", i), int'(out_valid), int'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                check($sformatf("v%0d_out_data", i), int'(out_data), int'(vecs[i].exp_data));
            check($sformatf("v%0d_busy", i), int'(busy), int'(vecs[i].exp_busy));
            check($sformatf("v%0d_words_read", i), int'(words_read), int'(vecs[i].exp_words));
        end
        check("stream_rd_pulses", rd_pulses, 8);
        check("stream_err_count", int'(rd_err_count), 0);

        // A lone word must be fetched with exactly one read strobe.
        base = acc_q.size(); p0 = rd_pulses;
        load(8'hA5);
        enable = 1'b1;
        repeat (10) @(negedge clk);
        check("single_rd_pulses", rd_pulses - p0, 1);
        check("single_words", acc_q.size() - base, 1);
        check("single_data", acc_at(base), 'hA5);
        check("single_err_count", int'(rd_err_count), 0);
        enable = 1'b0;
        wait_idle("single_idle");

        // Sink stalled: reads stop once the skid credits are spent, nothing is lost.
        base = acc_q.size(); p0 = rd_pulses;
        for (int i = 0; i < 8; i++) load(8'h31 + 8'(i));
        enable = 1'b1; out_ready = 1'b0;
        repeat (10) @(negedge clk);
        check("stall_rd_pulses", rd_pulses - p0, SD);
        check("stall_fifo_rd", int'(fifo_rd), 0);
        check("stall_out_valid", int'(out_valid), 1);
        check("stall_out_data", int'(out_data), 'h31);
        out_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("stall_words", acc_q.size() - base, 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("stall_order%0d", i), acc_at(base + i), 'h31 + i);
        check("stall_words_read", int'(words_read), 17);
        enable = 1'b0;
        wait_idle("stall_idle");

        // Enable dropped with two reads in flight.
        base = acc_q.size(); p0 = rd_pulses;
        for (int i = 0; i < 6; i++) load(8'h41 + 8'(i));
        enable = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("drop_state_drain", int'(dut.state), int'(ST_DRAIN));
        wait_idle("drop_idle");
        check("drop_state_idle", int'(dut.state), int'(ST_IDLE));
        repeat (3) @(negedge clk);
        check("drop_rd_pulses", rd_pulses - p0, 2);
        check("drop_words", acc_q.size() - base, 2);
        check("drop_word0", acc_at(base), 'h41);
        check("drop_word1", acc_at(base + 1), 'h42);

        // Reset while three words sit in the skid buffer.
        enable = 1'b1; out_ready = 1'b0;
        repeat (6) @(negedge clk);
        check("prerst_skid_count", int'(dut.skid_count), 3);
        check("prerst_out_data", int'(out_data), 'h43);
        reset = 1'b1; enable = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_words_read", int'(words_read), 0);
        check("midrst_fifo_rd", int'(fifo_rd), 0);
        check("midrst_state", int'(dut.state), int'(ST_IDLE));
        check("midrst_busy", int'(busy), 0);
        reset = 1'b0; out_ready = 1'b1;

        // Error counter saturates.
        ext_err = 1'b1;
        repeat (100) @(negedge clk);
        check("err_count_100", int'(rd_err_count), 100);
        repeat (155) @(negedge clk);
        check("err_count_255", int'(rd_err_count), 255);
        repeat (45) @(negedge clk);
        check("err_count_300", int'(rd_err_count), 255);
        ext_err = 1'b0;

        check("skid_never_overflows", int'(max_skid <= SD), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
